ram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that sits directly upstream of the 16x8 RAM.
- It turns a push/pop handshake into RAM write/read strobes and addresses, and tracks occupancy with wrapping pointers.
- It returns RAM read data to the consumer with a valid flag.
- Top-level integration instantiates this block plus the RAM; the RAM is the storage array.

---
 rtl/ram_fifo_pkg.sv | 12 +
 rtl/ram_fifo_ptr.sv | 20 ++
 rtl/ram_fifo_ctrl.sv | 108 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared widths and types for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;

endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrapping RAM pointer with increment and synchronous clear.
module ram_fifo_ptr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external registered-read RAM.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ram_fifo_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ram_fifo_pkg::DATA_WIDTH,
  parameter int DEPTH      = ram_fifo_pkg::DEPTH,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  input  logic                  pop_req,
  output logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  push_err,
  output logic                  pop_err,
  output logic                  ram_wr_enb,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_enb,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic                  push_acc;
  logic                  pop_acc;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);
  assign push_ready   = !full;
  assign pop_ready    = !empty;

  assign push_acc = push_valid && !full && !flush && !rst;
  assign pop_acc  = pop_req && !empty && !flush && !rst;

  assign ram_wr_enb  = push_acc;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = push_data;
  assign ram_rd_enb  = pop_acc;
  assign ram_rd_addr = rd_ptr;

  // The RAM holds its output register, so data passes straight through.
  assign pop_data = ram_rd_data;

  ram_fifo_ptr #(
    .WIDTH(ADDR_WIDTH)
  ) u_wr_ptr (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .inc(push_acc),
    .ptr(wr_ptr)
  );

  ram_fifo_ptr #(
    .WIDTH(ADDR_WIDTH)
  ) u_rd_ptr (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .inc(pop_acc),
    .ptr(rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_valid <= 1'b0;
      push_err  <= 1'b0;
      pop_err   <= 1'b0;
    end else begin
      pop_valid <= pop_acc;
      push_err  <= push_valid && full && !flush;
      pop_err   <= pop_req && empty && !flush;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 16x8 RAM.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       push_valid;
  logic [7:0] push_data;
  logic       push_ready;
  logic       pop_req;
  logic       pop_ready;
  logic [7:0] pop_data;
  logic       pop_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       push_err;
  logic       pop_err;
  logic       ram_wr_enb;
  logic [3:0] ram_wr_addr;
  logic [7:0] ram_wr_data;
  logic       ram_rd_enb;
  logic [3:0] ram_rd_addr;
  logic [7:0] ram_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .push_valid(push_valid),
    .push_data(push_data),
    .push_ready(push_ready),
    .pop_req(pop_req),
    .pop_ready(pop_ready),
    .pop_data(pop_data),
    .pop_valid(pop_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .push_err(push_err),
    .pop_err(pop_err),
    .ram_wr_enb(ram_wr_enb),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd_enb(ram_rd_enb),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data)
  );

  logic [7:0] mem [16];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      ram_rd_data <= 8'h00;
    end else begin
      if (ram_wr_enb) mem[ram_wr_addr] <= ram_wr_data;
      if (ram_rd_enb) ram_rd_data <= mem[ram_rd_addr];
    end
  end

  typedef struct {
    logic       pv;
    logic [7:0] pd;
    logic       pr;
    logic [4:0] cnt;
    logic       vld;
    logic [7:0] dat;
    logic       full;
    logic       empty;
    logic       perr;
    logic       rerr;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [7:0] pd,
                       input logic pr, input logic fl);
    push_valid = pv;
    push_data  = pd;
    pop_req    = pr;
    flush      = fl;
  endtask

  // Inputs change at negedge; results of the posedge are read at the next negedge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 5'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 5'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    drive(1'b1, 8'hEE, 1'b1, 1'b0);
    step();
    chk("rst_wr_enb", ram_wr_enb, 0);
    chk("rst_rd_enb", ram_rd_enb, 0);
    step();
    rst = 1'b0;
    idle();
    step();
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_push_ready", push_ready, 1);
    chk("reset_pop_ready", pop_ready, 0);
    chk("reset_pop_valid", pop_valid, 0);
    chk("reset_ae", almost_empty, 1);
    chk("reset_af", almost_full, 0);
    chk("idle_wr_enb", ram_wr_enb, 0);
    chk("idle_rd_enb", ram_rd_enb, 0);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].pv, tbl[i].pd, tbl[i].pr, 1'b0);
      step();
      chk($sformatf("row%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("row%0d_full", i), full, tbl[i].full);
      chk($sformatf("row%0d_empty", i), empty, tbl[i].empty);
      chk($sformatf("row%0d_pop_valid", i), pop_valid, tbl[i].vld);
      chk($sformatf("row%0d_push_err", i), push_err, tbl[i].perr);
      chk($sformatf("row%0d_pop_err", i), pop_err, tbl[i].rerr);
      if (tbl[i].vld) chk($sformatf("row%0d_data", i), pop_data, tbl[i].dat);
    end

    // Fill to full with 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      step();
      if (i == 11) chk("af_at_12", almost_full, 1);
      if (i == 10) chk("af_at_11", almost_full, 0);
    end
    idle();
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_push_ready", push_ready, 0);
    chk("fill_ae", almost_empty, 0);
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    #1;
    chk("ovf_wr_enb", ram_wr_enb, 0);
    step();
    chk("ovf_push_err", push_err, 1);
    chk("ovf_count", count, 16);
    idle();
    step();
    chk("ovf_err_pulse", push_err, 0);

    // Full blocks the push even with a pop in the same cycle.
    drive(1'b1, 8'hEE, 1'b1, 1'b0);
    step();
    chk("fullpp_count", count, 15);
    chk("fullpp_valid", pop_valid, 1);
    chk("fullpp_data", pop_data, 8'h00);
    chk("fullpp_push_err", push_err, 1);
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    step();
    chk("a5_count", count, 16);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      step();
      chk($sformatf("wrap_valid%0d", i), pop_valid, 1);
      chk($sformatf("wrap_data%0d", i), pop_data,
          (i < 15) ? 32'(i + 1) : 32'hA5);
    end
    idle();
    step();
    chk("wrap_empty", empty, 1);
    chk("wrap_valid_drop", pop_valid, 0);

    // Steady state at count=5 with simultaneous push and pop.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      step();
    end
    chk("pp_pre_count", count, 5);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
      step();
      chk($sformatf("pp_count%0d", i), count, 5);
      chk($sformatf("pp_data%0d", i), pop_data,
          (i < 5) ? 32'(8'h40 + i) : 32'(8'h50 + i - 5));
    end

    // Flush at count=7 with a pop still returning data.
    drive(1'b1, 8'h60, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h61, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h62, 1'b1, 1'b0);
    step();
    chk("pfl_count", count, 7);
    chk("pfl_data", pop_data, 8'h55);
    drive(1'b1, 8'h70, 1'b1, 1'b1);
    #1;
    chk("fl_wr_enb", ram_wr_enb, 0);
    chk("fl_rd_enb", ram_rd_enb, 0);
    chk("fl_inflight_valid", pop_valid, 1);
    chk("fl_inflight_data", pop_data, 8'h55);
    step();
    chk("fl_count", count, 0);
    chk("fl_empty", empty, 1);
    chk("fl_valid", pop_valid, 0);
    chk("fl_push_err", push_err, 0);
    idle();
    step();
    chk("fl_count_hold", count, 0);

    // Reset right after an accepted pop.
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    step();
    chk("rp_valid", pop_valid, 1);
    chk("rp_data", pop_data, 8'h77);
    rst = 1'b1;
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    #1;
    chk("rp_wr_forced", ram_wr_enb, 0);
    step();
    chk("rp_valid_drop", pop_valid, 0);
    chk("rp_count", count, 0);
    rst = 1'b0;
    idle();
    step();
    chk("rp_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
